comp_in_arb: RTL and testbench
==============================

Name: comp_in_arb

Overview:
Round-robin input arbiter that shares one compression datapath (SR/ZRL/BPC engines plus selector) among N_REQ independent 64-bit block streams. It grants one requester at a time for exactly one 8-beat (512-bit) block, sop to eop, so blocks never interleave at the compressor input. It regenerates framing, reports which requester owns each beat, and flags framing violations. It sits between the requester DMA ports and the compressor top's data_i/valid_i/sop_i/eop_i/ready_o.

Parameters:
N_REQ, 4, number of requesters (2..16)
D_WIDTH, 64, beat data width
BLK_BEATS, 8, beats per compression block (power of two)
ID_W, $clog2(N_REQ), grant id width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_data_i  in  N_REQ*D_WIDTH  packed requester beats; requester k at [k*D_WIDTH +: D_WIDTH]
req_valid_i  in  N_REQ  per-requester beat valid
req_sop_i  in  N_REQ  per-requester start of block
req_eop_i  in  N_REQ  per-requester end of block
req_ready_o  out  N_REQ  per-requester accept
data_o  out  D_WIDTH  beat to compressor
valid_o  out  1  beat valid to compressor
sop_o  out  1  regenerated start of block
eop_o  out  1  regenerated end of block
ready_i  in  1  compressor ready (compressor ready_o)
gnt_id_o  out  ID_W  owner of current beat; valid with valid_o
busy_o  out  1  high while in BURST
err_o  out  1  one-cycle pulse on a framing violation

Behaviour:
- Reset (asynchronous, active-high), at any time including mid-burst: state=IDLE, rr_ptr=0, beat_cnt=0, gnt_id=0. Outputs: valid_o=0, sop_o=0, eop_o=0, req_ready_o=0, busy_o=0, err_o=0, data_o=0. The partial block is abandoned; the compressor sees no eop.
- Handshake: a beat transfers when valid_o & ready_i. For the granted requester g, req_ready_o[g] = ready_i, and req_ready_o is 0 for all other requesters.
- FSM, two states:
  - IDLE: candidates are requesters with req_valid_i & req_sop_i. The rr_arb sub-module picks the first candidate at or after rr_ptr, wrapping modulo N_REQ. On a win: register gnt_id=winner, beat_cnt=0, go to BURST. The winning beat is not consumed in IDLE; it stays on the requester port. This gives a one-cycle arbitration bubble, so peak throughput is 8 beats per 9 cycles.
  - IDLE stray beats: any requester with req_valid_i=1 and req_sop_i=0 is a stray beat. It gets req_ready_o=1 (discarded) and err_o pulses. Discard has priority over arbitration only for that requester, not for others.
  - BURST: data_o = req_data_i[g]; valid_o = req_valid_i[g]; sop_o = valid_o & (beat_cnt==0); eop_o = valid_o & (beat_cnt==BLK_BEATS-1); busy_o=1. beat_cnt increments on each handshake.
  - BURST end: on the handshake with beat_cnt==BLK_BEATS-1, set rr_ptr=(g+1) mod N_REQ, beat_cnt=0, and go to IDLE.
- Framing check in BURST: on a handshake, err_o pulses if req_sop_i[g] != (beat_cnt==0) or req_eop_i[g] != (beat_cnt==BLK_BEATS-1). Block length is always BLK_BEATS regardless of requester framing; the requester eop does not end the burst early.
- Bubbles: req_valid_i[g]=0 mid-burst stalls with no timeout. ready_i=0 holds beat_cnt, and data_o/valid_o follow the requester, which must hold its beat stable.
- beat_cnt is $clog2(BLK_BEATS) bits and wraps naturally. rr_ptr is ID_W bits; the wrap from N_REQ-1 goes to 0 explicitly, since N_REQ may not be a power of two.
- Simultaneous events: if several candidates are present in IDLE, only one is granted; the rest keep ready=0. A stray discard and an arbitration win in the same cycle both proceed.

Decomposition:
- Shared package comp_pkg holds:
  - constants BLK_BEATS=8 and D_WIDTH=64, also used by the compressor FIFOs;
  - arb state enum {ARB_IDLE, ARB_BURST};
  - the err cause encoding (reserved for a future status register).
- One combinational sub-module, rr_arb: inputs req vector and ptr; outputs winner id and any_valid. It is reused by future output-side schedulers.

Test Plan:
- Single requester 1 sends an 8-beat block 0x10..0x17 with ready_i=1 → valid_o goes high one cycle after its sop. Output is 8 consecutive beats with gnt_id_o=1, sop_o on 0x10, eop_o on 0x17, err_o never pulses.
- All 4 requesters hold sop at once, back-to-back blocks → grant order is 0,1,2,3,0. Exactly 8 beats per grant with one idle cycle between blocks: 36 cycles for 4 blocks.
- ready_i toggled 1,0 every cycle during a burst → each data value appears exactly once on a handshake. beat_cnt holds on stalls, and eop_o occurs on the 8th handshake.
- Requester 2 asserts eop_i on beat 5 → err_o pulses once at that handshake. Burst still runs 8 beats, and eop_o is on the 8th beat.
- In IDLE, requester 3 has valid=1 and sop=0 for 2 cycles → req_ready_o[3]=1 for both cycles, err_o pulses twice, and no grant is issued to 3.
- Reset asserted at beat 4 of a burst → outputs go to 0 immediately, without waiting for clk. After release, arbitration restarts at requester 0 with beat_cnt=0.

Source files
------------

// File: rtl/comp_pkg.sv
// comp_pkg: constants and enums shared by the compression front end
package comp_pkg;
  localparam int BLK_BEATS = 8;
  localparam int D_WIDTH = 64;
  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
  typedef enum logic [1:0] {ERR_NONE, ERR_STRAY, ERR_SOP, ERR_EOP} err_cause_t;
endpackage

// File: rtl/rr_arb.sv
// rr_arb: combinational round-robin pick of the first request at or after ptr
module rr_arb #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] id,
  output logic         any
);
  int j;
  // scan from the farthest offset down so the nearest request at/after ptr wins
  always_comb begin
    id = '0;
    any = 1'b0;
    j = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      j = j >= N ? j - N : j;
      if (req[j]) begin
        id = W'(j);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/comp_in_arb.sv
// comp_in_arb: round-robin arbiter granting one requester a whole block at a time
module comp_in_arb #(
  parameter int N_REQ = 4,
  parameter int D_WIDTH = comp_pkg::D_WIDTH,
  parameter int BLK_BEATS = comp_pkg::BLK_BEATS,
  parameter int ID_W = $clog2(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ*D_WIDTH-1:0] req_data_i,
  input  logic [N_REQ-1:0]         req_valid_i,
  input  logic [N_REQ-1:0]         req_sop_i,
  input  logic [N_REQ-1:0]         req_eop_i,
  output logic [N_REQ-1:0]         req_ready_o,
  output logic [D_WIDTH-1:0]       data_o,
  output logic                     valid_o,
  output logic                     sop_o,
  output logic                     eop_o,
  input  logic                     ready_i,
  output logic [ID_W-1:0]          gnt_id_o,
  output logic                     busy_o,
  output logic                     err_o
);
  import comp_pkg::*;
  localparam int CW = $clog2(BLK_BEATS);
  arb_state_t state, state_nxt;
  err_cause_t cause;
  logic [ID_W-1:0] gnt_id, rr_ptr, win_id;
  logic [CW-1:0] beat_cnt;
  logic [N_REQ-1:0] cand, stray;
  logic any_cand, burst, first, last, hs;
  assign cand = req_valid_i & req_sop_i;
  assign stray = req_valid_i & ~req_sop_i;
  assign burst = state == ARB_BURST;
  assign gnt_id_o = gnt_id;
  rr_arb #(.N(N_REQ), .W(ID_W)) u_rr (
    .req(cand),
    .ptr(rr_ptr),
    .id(win_id),
    .any(any_cand)
  );
  // datapath mux, regenerated framing, stray discard and framing checks; idle-side
  // outputs are masked by rst so nothing leaks out while reset is held
  always_comb begin
    busy_o = burst;
    valid_o = burst & req_valid_i[gnt_id];
    data_o = burst ? req_data_i[int'(gnt_id)*D_WIDTH +: D_WIDTH] : '0;
    first = beat_cnt == '0;
    last = beat_cnt == CW'(BLK_BEATS - 1);
    sop_o = valid_o & first;
    eop_o = valid_o & last;
    hs = valid_o & ready_i;
    req_ready_o = burst ? N_REQ'(ready_i) << gnt_id : (rst ? '0 : stray);
    cause = !burst ? ((|stray && !rst) ? ERR_STRAY : ERR_NONE) :
            !hs ? ERR_NONE :
            req_sop_i[gnt_id] != first ? ERR_SOP :
            req_eop_i[gnt_id] != last ? ERR_EOP : ERR_NONE;
    err_o = cause != ERR_NONE;
    state_nxt = burst ? ((hs && last) ? ARB_IDLE : ARB_BURST) : (any_cand ? ARB_BURST : ARB_IDLE);
  end
  // state, grant owner, beat counter and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      rr_ptr <= '0;
      beat_cnt <= '0;
      gnt_id <= '0;
    end else begin
      state <= state_nxt;
      if (!burst && any_cand) begin
        gnt_id <= win_id;
        beat_cnt <= '0;
      end
      if (hs) beat_cnt <= beat_cnt + 1'b1;
      if (hs && last) rr_ptr <= gnt_id == ID_W'(N_REQ - 1) ? '0 : gnt_id + 1'b1;
    end
  end
endmodule

// File: tb/tb_comp_in_arb.sv
// tb_comp_in_arb: table, directed and randomized checks of the block arbiter
module tb_comp_in_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [255:0] req_data_i = '0;
  logic [3:0] req_valid_i = '0, req_sop_i = '0, req_eop_i = '0, req_ready_o;
  logic [63:0] data_o;
  logic valid_o, sop_o, eop_o, busy_o, err_o;
  logic ready_i = 1'b0;
  logic [1:0] gnt_id_o;
  int n_cmp = 0, n_err = 0;
  int idx[4], blk[4];
  logic [3:0] v = '0, eop_early = '0;
  bit rnd = 0;
  typedef struct {
    logic [3:0] v, s, exp_rdy;
    logic exp_err, exp_busy;
  } vec_t;
  vec_t tbl[6];

  comp_in_arb dut (
    .clk(clk), .rst(rst), .req_data_i(req_data_i), .req_valid_i(req_valid_i),
    .req_sop_i(req_sop_i), .req_eop_i(req_eop_i), .req_ready_o(req_ready_o),
    .data_o(data_o), .valid_o(valid_o), .sop_o(sop_o), .eop_o(eop_o),
    .ready_i(ready_i), .gnt_id_o(gnt_id_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(int k, int b, int i);
    return {16'(k), 32'(b), 16'(16 + i)};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      req_data_i[k*64 +: 64] = pat(k, blk[k], idx[k]);
      req_sop_i[k] = idx[k] == 0;
      req_eop_i[k] = idx[k] == 7 || (eop_early[k] && idx[k] == 4);
    end
    req_valid_i = v;
  endtask

  task automatic advance();
    for (int k = 0; k < 4; k++)
      if (req_valid_i[k] && req_ready_o[k]) begin
        idx[k] = (idx[k] + 1) % 8;
        if (idx[k] == 0) blk[k]++;
        if (rnd) v[k] = 1'b0;
      end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v = '0;
    req_valid_i = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx[k] = 0;
      blk[k] = 0;
    end
  endtask

  initial begin
    int order[$];
    int nhs, nerr, done_cyc, m_owner, m_beat, m_ptr;
    bit m_busy, exp_valid, hs_exp;
    logic [3:0] cand;
    tbl[0] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
    tbl[1] = '{4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b0};
    tbl[2] = '{4'b1000, 4'b0000, 4'b1000, 1'b1, 1'b0};
    tbl[3] = '{4'b0101, 4'b0000, 4'b0101, 1'b1, 1'b0};
    tbl[4] = '{4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b0};
    tbl[5] = '{4'b0000, 4'b1111, 4'b0000, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      idx[k] = 0;
      blk[k] = 0;
    end
    // reset state, with stray beats present that must stay masked
    @(negedge clk);
    req_valid_i = 4'hf;
    ready_i = 1'b1;
    #1;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_sop_eop", {sop_o, eop_o}, 0);
    chk("rst_gnt", gnt_id_o, 0);
    rst = 1'b0;
    req_valid_i = '0;
    @(negedge clk);
    // idle stray-beat table
    foreach (tbl[i]) begin
      req_valid_i = tbl[i].v;
      req_sop_i = tbl[i].s;
      req_eop_i = '0;
      #1;
      chk($sformatf("tbl%0d_ready", i), req_ready_o, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_err", i), err_o, tbl[i].exp_err);
      chk($sformatf("tbl%0d_busy", i), busy_o, tbl[i].exp_busy);
      @(negedge clk);
    end
    // single block from requester 1
    v = 4'b0010;
    ready_i = 1'b1;
    drive();
    #1;
    chk("t2_bubble_valid", valid_o, 0);
    chk("t2_bubble_ready", req_ready_o, 0);
    advance();
    @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      drive();
      #1;
      chk("t2_valid", valid_o, 1);
      chk("t2_gnt", gnt_id_o, 1);
      chk("t2_data", data_o, pat(1, 0, b));
      chk("t2_sop", sop_o, b == 0);
      chk("t2_eop", eop_o, b == 7);
      chk("t2_err", err_o, 0);
      advance();
      @(negedge clk);
    end
    v = '0;
    drive();
    #1;
    chk("t2_idle_after", busy_o, 0);
    @(negedge clk);
    // four requesters back to back
    do_reset();
    v = 4'b1111;
    ready_i = 1'b1;
    nhs = 0;
    nerr = 0;
    done_cyc = 0;
    for (int c = 1; c <= 60 && order.size() < 5; c++) begin
      drive();
      #1;
      if (valid_o && ready_i) begin
        nhs++;
        if (sop_o) order.push_back(int'(gnt_id_o));
        if (eop_o && nhs == 32) done_cyc = c;
      end
      nerr += int'(err_o);
      advance();
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) chk($sformatf("t3_order%0d", i), i < order.size() ? order[i] : -1, i % 4);
    chk("t3_cycles", done_cyc, 36);
    chk("t3_err", nerr, 0);
    v = '0;
    // ready toggling every cycle
    do_reset();
    v = 4'b0001;
    nhs = 0;
    for (int c = 0; c < 40 && nhs < 8; c++) begin
      drive();
      ready_i = c[0];
      #1;
      if (valid_o && ready_i) begin
        chk("t4_data", data_o, pat(0, 0, nhs));
        chk("t4_sop", sop_o, nhs == 0);
        chk("t4_eop", eop_o, nhs == 7);
        nhs++;
      end else if (valid_o) chk("t4_stall_ready", req_ready_o, 0);
      advance();
      @(negedge clk);
    end
    chk("t4_beats", nhs, 8);
    v = '0;
    // requester 2 raises eop early on its fifth beat
    v = 4'b0100;
    eop_early = 4'b0100;
    ready_i = 1'b1;
    nhs = 0;
    nerr = 0;
    for (int c = 0; c < 20 && nhs < 8; c++) begin
      drive();
      #1;
      hs_exp = valid_o && ready_i;
      chk("t5_err", err_o, hs_exp && nhs == 4);
      nerr += int'(err_o);
      if (hs_exp) begin
        chk("t5_eop", eop_o, nhs == 7);
        nhs++;
      end
      advance();
      @(negedge clk);
    end
    chk("t5_beats", nhs, 8);
    chk("t5_err_count", nerr, 1);
    v = '0;
    eop_early = '0;
    // asynchronous reset in the middle of a burst from requester 1
    v = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      drive();
      advance();
      @(negedge clk);
    end
    drive();
    #1;
    chk("t7_pre_valid", valid_o, 1);
    chk("t7_pre_gnt", gnt_id_o, 1);
    rst = 1'b1;
    #1;
    chk("t7_valid", valid_o, 0);
    chk("t7_busy", busy_o, 0);
    chk("t7_ready", req_ready_o, 0);
    chk("t7_err", err_o, 0);
    chk("t7_data", data_o, 0);
    chk("t7_sop_eop", {sop_o, eop_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx[k] = 0;
      blk[k] = 0;
    end
    v = 4'b1001;
    drive();
    #1;
    chk("t7_idle", busy_o, 0);
    advance();
    @(negedge clk);
    drive();
    #1;
    chk("t7_restart_gnt", gnt_id_o, 0);
    chk("t7_restart_sop", sop_o, 1);
    chk("t7_restart_data", data_o, pat(0, 0, 0));
    // randomized traffic against a block-level model
    do_reset();
    rnd = 1;
    m_busy = 0;
    m_owner = 0;
    m_beat = 0;
    m_ptr = 0;
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 4; k++) if (!v[k]) v[k] = $urandom_range(0, 3) != 0;
      ready_i = $urandom_range(0, 3) != 0;
      drive();
      #1;
      exp_valid = m_busy && v[m_owner];
      hs_exp = exp_valid && ready_i;
      chk("rnd_busy", busy_o, m_busy);
      chk("rnd_valid", valid_o, exp_valid);
      chk("rnd_ready", req_ready_o, (m_busy && ready_i) ? 4'(1 << m_owner) : 4'b0);
      chk("rnd_err", err_o, 0);
      if (m_busy) chk("rnd_gnt", gnt_id_o, m_owner);
      if (hs_exp) begin
        chk("rnd_data", data_o, pat(m_owner, blk[m_owner], idx[m_owner]));
        chk("rnd_sop", sop_o, m_beat == 0);
        chk("rnd_eop", eop_o, m_beat == 7);
      end
      if (!m_busy) begin
        for (int k = 0; k < 4; k++) cand[k] = v[k] && idx[k] == 0;
        for (int i = 3; i >= 0; i--)
          if (cand[(m_ptr + i) % 4]) begin
            m_owner = (m_ptr + i) % 4;
            m_busy = 1;
            m_beat = 0;
          end
      end else if (hs_exp) begin
        m_beat++;
        if (m_beat == 8) begin
          m_busy = 0;
          m_ptr = (m_owner + 1) % 4;
        end
      end
      advance();
      @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
